decode_stage_fifo: RTL and testbench

- Parametrised next-generation instruction-decode pipeline stage.
- Sits between fetch and execute. Uses the same DIR/ack_prev (upstream) and DOR/ack_from_next (downstream) pulse handshake.
- Adds a DEPTH-entry elastic buffer so upstream is not stalled while downstream is busy.
- Presents the head instruction word plus decoded opcode and illegal-opcode flag.

---
 rtl/decode_stage_fifo.sv | 91 +++++++++
 tb/tb_decode_stage_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_fifo.sv
// decode_stage_fifo: decode stage with a DEPTH-entry elastic buffer between the fetch and execute handshakes.
// Define DECODE_STAGE_STATS_EN to add saturating accepted/stall/illegal counters.
module decode_stage_fifo #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 4,
   parameter int OPCODE_BITS = 6,
   parameter int NUM_OPCODES = 40
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         DIR,
   input  logic [DATA_WIDTH-1:0]        data_in,
   output logic                         ack_prev,
   output logic                         DOR,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic [OPCODE_BITS-1:0]       opcode,
   output logic                         illegal,
   input  logic                         ack_from_next,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
`ifdef DECODE_STAGE_STATS_EN
   ,
   output logic [15:0]                  stat_accepted,
   output logic [15:0]                  stat_stalls,
   output logic [15:0]                  stat_illegal
`endif
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {ACCEPT, ACKED} state_t;

   state_t                  state, state_nxt;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [PW-1:0]           wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic                    push, pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign DOR      = !empty;
   assign opcode   = data_out[DATA_WIDTH-1 -: OPCODE_BITS];
   assign illegal  = DOR && (int'(opcode) >= NUM_OPCODES);
   assign ack_prev = (state == ACKED);
   assign pop      = DOR && ack_from_next;
   assign wr_nxt   = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
   assign rd_nxt   = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

   // The ACKED state masks capture while upstream is still seeing the ack pulse.
   always_comb begin
      push      = DIR && !full && (state == ACCEPT);
      state_nxt = push ? ACKED : ACCEPT;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ACCEPT;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         data_out <= '0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_nxt;
         if (pop) rd_ptr <= rd_nxt;
         if (push && !pop) count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         // data_out mirrors the head; an incoming word becomes head only when nothing else remains.
         if (push && (empty || (pop && count == CW'(1)))) data_out <= data_in;
         else if (pop && count > CW'(1)) data_out <= mem[rd_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

`ifdef DECODE_STAGE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_accepted <= '0;
         stat_stalls   <= '0;
         stat_illegal  <= '0;
      end else begin
         if (push && stat_accepted != 16'hFFFF) stat_accepted <= stat_accepted + 16'd1;
         if (DIR && full && stat_stalls != 16'hFFFF) stat_stalls <= stat_stalls + 16'd1;
         if (pop && illegal && stat_illegal != 16'hFFFF) stat_illegal <= stat_illegal + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_decode_stage_fifo.sv
// tb_decode_stage_fifo: directed checks of decode_stage_fifo (DEPTH=4 main instance, DEPTH=3 for wrap).
module tb_decode_stage_fifo;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        dir = 1'b0, ack_next = 1'b0;
   logic [31:0] din = '0;
   logic        ack_prev, dor, illegal, full, empty;
   logic [31:0] dout;
   logic [5:0]  opcode;
   logic [2:0]  count;
   logic        dir3 = 1'b0, ack3 = 1'b0;
   logic [31:0] din3 = '0;
   logic        ack_prev3, dor3, illegal3, full3, empty3;
   logic [31:0] dout3;
   logic [5:0]  opcode3;
   logic [1:0]  count3;
   int          errors = 0, checks = 0;
`ifdef DECODE_STAGE_STATS_EN
   logic [15:0] st_acc, st_stall, st_ill, st_acc3, st_stall3, st_ill3;
`endif

   always #5 clk = ~clk;

   decode_stage_fifo #(.DEPTH(4)) u_dut (
      .clk(clk), .reset(reset), .DIR(dir), .data_in(din), .ack_prev(ack_prev),
      .DOR(dor), .data_out(dout), .opcode(opcode), .illegal(illegal),
      .ack_from_next(ack_next), .count(count), .full(full), .empty(empty)
`ifdef DECODE_STAGE_STATS_EN
      , .stat_accepted(st_acc), .stat_stalls(st_stall), .stat_illegal(st_ill)
`endif
   );

   decode_stage_fifo #(.DEPTH(3)) u_dut3 (
      .clk(clk), .reset(reset), .DIR(dir3), .data_in(din3), .ack_prev(ack_prev3),
      .DOR(dor3), .data_out(dout3), .opcode(opcode3), .illegal(illegal3),
      .ack_from_next(ack3), .count(count3), .full(full3), .empty(empty3)
`ifdef DECODE_STAGE_STATS_EN
      , .stat_accepted(st_acc3), .stat_stalls(st_stall3), .stat_illegal(st_ill3)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      dir = 1'b1;
      din = w;
      step();
      dir = 1'b0;
      step();
   endtask

   task automatic pop();
      ack_next = 1'b1;
      step();
      ack_next = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if ({empty, full, dor, ack_prev} !== 4'b1000) begin errors++; $display("FAIL reset_flags got=%b exp=1000", {empty, full, dor, ack_prev}); end
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", dout); end
      checks++; if ({opcode, illegal} !== 7'h0) begin errors++; $display("FAIL reset_opcode got=%h/%b exp=0/0", opcode, illegal); end
      checks++; if (count3 !== 2'd0 || dor3 !== 1'b0) begin errors++; $display("FAIL reset_dut3 got=%0d/%b exp=0/0", count3, dor3); end
   endtask

   task automatic test_single();
      dir = 1'b1;
      din = 32'h0800_0005;
      step();
      dir = 1'b0;
      checks++; if (ack_prev !== 1'b1) begin errors++; $display("FAIL single_ack got=%b exp=1", ack_prev); end
      checks++; if (dor !== 1'b1 || dout !== 32'h0800_0005) begin errors++; $display("FAIL single_head got=%b/%h exp=1/08000005", dor, dout); end
      checks++; if (opcode !== 6'd2 || illegal !== 1'b0) begin errors++; $display("FAIL single_opcode got=%0d/%b exp=2/0", opcode, illegal); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
      step();
      checks++; if (ack_prev !== 1'b0) begin errors++; $display("FAIL single_ack_drop got=%b exp=0", ack_prev); end
      pop();
      checks++; if (dor !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_pop got=%b/%0d/%b exp=0/0/1", dor, count, empty); end
      checks++; if (dout !== 32'h0800_0005) begin errors++; $display("FAIL single_hold got=%h exp=08000005", dout); end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 4; i++) push(32'(i));
      checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL fill_full got=%b/%0d exp=1/4", full, count); end
      checks++; if (dout !== 32'd1) begin errors++; $display("FAIL fill_head got=%0d exp=1", dout); end
      dir = 1'b1;
      din = 32'd5;
      step();
      checks++; if (ack_prev !== 1'b0 || count !== 3'd4) begin errors++; $display("FAIL fill_refuse got=%b/%0d exp=0/4", ack_prev, count); end
      pop();
      checks++; if (ack_prev !== 1'b0 || count !== 3'd3 || dout !== 32'd2) begin errors++; $display("FAIL fill_pop_refuse got=%b/%0d/%0d exp=0/3/2", ack_prev, count, dout); end
      step();
      dir = 1'b0;
      checks++; if (ack_prev !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL fill_retry got=%b/%0d exp=1/4", ack_prev, count); end
      step();
      for (int i = 2; i <= 5; i++) begin
         checks++; if (dout !== 32'(i) || dor !== 1'b1) begin errors++; $display("FAIL fill_drain got=%0d/%b exp=%0d/1", dout, dor, i); end
         pop();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty got=%b exp=1", empty); end
   endtask

   task automatic test_simultaneous();
      push(32'd10);
      push(32'd11);
      checks++; if (count !== 3'd2 || dout !== 32'd10) begin errors++; $display("FAIL simul_pre got=%0d/%0d exp=2/10", count, dout); end
      dir = 1'b1;
      din = 32'd12;
      ack_next = 1'b1;
      step();
      dir = 1'b0;
      ack_next = 1'b0;
      checks++; if (count !== 3'd2 || ack_prev !== 1'b1) begin errors++; $display("FAIL simul_count got=%0d/%b exp=2/1", count, ack_prev); end
      checks++; if (dout !== 32'd11) begin errors++; $display("FAIL simul_head got=%0d exp=11", dout); end
      step();
      for (int i = 11; i <= 12; i++) begin
         checks++; if (dout !== 32'(i)) begin errors++; $display("FAIL simul_drain got=%0d exp=%0d", dout, i); end
         pop();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty got=%b exp=1", empty); end
   endtask

   task automatic test_wrap();
      dir3 = 1'b1;
      din3 = 32'd100;
      step();
      dir3 = 1'b0;
      step();
      for (int i = 0; i < 10; i++) begin
         dir3 = 1'b1;
         din3 = 32'(i);
         ack3 = 1'b1;
         step();
         dir3 = 1'b0;
         ack3 = 1'b0;
         checks++; if (dout3 !== ((i == 0) ? 32'd0 : 32'(i - 1)) && i == 0 && dout3 !== 32'd0) begin errors++; $display("FAIL wrap_first got=%0d exp=0", dout3); end
         checks++; if (count3 !== 2'd1) begin errors++; $display("FAIL wrap_count got=%0d exp=1", count3); end
         checks++; if (dout3 !== 32'(i)) begin errors++; $display("FAIL wrap_head got=%0d exp=%0d", dout3, i); end
         step();
      end
      ack3 = 1'b1;
      step();
      ack3 = 1'b0;
      checks++; if (empty3 !== 1'b1 || dout3 !== 32'd9) begin errors++; $display("FAIL wrap_end got=%b/%0d exp=1/9", empty3, dout3); end
   endtask

   task automatic test_illegal();
      push(32'hFC00_0000);
      checks++; if (illegal !== 1'b1 || opcode !== 6'd63) begin errors++; $display("FAIL illegal_flag got=%b/%0d exp=1/63", illegal, opcode); end
      checks++; if (dout !== 32'hFC00_0000) begin errors++; $display("FAIL illegal_data got=%h exp=fc000000", dout); end
      pop();
      checks++; if (illegal !== 1'b0 || dor !== 1'b0 || opcode !== 6'd63) begin errors++; $display("FAIL illegal_gate got=%b/%b/%0d exp=0/0/63", illegal, dor, opcode); end
`ifdef DECODE_STAGE_STATS_EN
      checks++; if (st_ill !== 16'd1) begin errors++; $display("FAIL stat_illegal got=%0d exp=1", st_ill); end
      checks++; if (st_acc !== 16'd10) begin errors++; $display("FAIL stat_accepted got=%0d exp=10", st_acc); end
      checks++; if (st_stall !== 16'd2) begin errors++; $display("FAIL stat_stalls got=%0d exp=2", st_stall); end
`endif
   endtask

   task automatic test_reset_mid();
      push(32'd1);
      push(32'd2);
      dir = 1'b1;
      din = 32'd3;
      step();
      checks++; if (count !== 3'd3 || ack_prev !== 1'b1) begin errors++; $display("FAIL mid_pre got=%0d/%b exp=3/1", count, ack_prev); end
      dir = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if ({dor, ack_prev} !== 2'b00 || count !== 3'd0 || dout !== 32'h0) begin errors++; $display("FAIL mid_reset got=%b%b/%0d/%h exp=00/0/0", dor, ack_prev, count, dout); end
`ifdef DECODE_STAGE_STATS_EN
      checks++; if ({st_acc, st_stall, st_ill} !== 48'h0) begin errors++; $display("FAIL mid_stats got=%h exp=0", {st_acc, st_stall, st_ill}); end
`endif
      push(32'h77);
      checks++; if (dout !== 32'h77 || count !== 3'd1) begin errors++; $display("FAIL mid_new got=%h/%0d exp=77/1", dout, count); end
      pop();
      checks++; if (empty !== 1'b1 || dout !== 32'h77) begin errors++; $display("FAIL mid_only got=%b/%h exp=1/77", empty, dout); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_simultaneous();
      test_wrap();
      test_illegal();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
